// File: rtl/dw_line_buffer.sv
// dw_line_buffer: raster-scan line buffer for the depthwise 3x3 row stage.
// Holds the two previous image rows and, for every accepted pixel, emits the
// vertical column {row y-2, row y-1, row y} at the same x with 1-cycle latency.
// Optional macro DW_PAD_EN: "same" zero padding. Row 1 emits with a zero top
// row, and a FLUSH pass after the last pixel emits the bottom pad row.
// Without the macro, only rows 2..IMG_H-1 emit and in_ready is tied high.
module dw_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pixel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_r0,
  output logic [DATA_W-1:0]        out_r1,
  output logic [DATA_W-1:0]        out_r2,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_row_first,
  output logic                     out_frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
`ifdef DW_PAD_EN
  // Padding mode starts emitting in row 1, so the buffer is primed after row 0.
  localparam logic [YW-1:0] FILL_ROW = '0;
`else
  localparam logic [YW-1:0] FILL_ROW = YW'(1);
`endif

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
  } col_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            parity;
  logic            accept;
  logic            x_last;
  logic            y_last;
  logic [DATA_W-1:0] old_px;
  logic [DATA_W-1:0] mid_px;
  col_t            run_col;
  col_t            col_q;

  // Line memories; contents are never reset since outputs gate on state.
  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];

`ifdef DW_PAD_EN
  logic rdy_q;
  assign in_ready = rdy_q;
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  assign out_r0 = col_q.r0;
  assign out_r1 = col_q.r1;
  assign out_r2 = col_q.r2;

  // Parity picks which memory holds the oldest row; the other holds the middle row.
  always_comb begin
    old_px = parity ? lb_b[x] : lb_a[x];
    mid_px = parity ? lb_a[x] : lb_b[x];
  end

  // Column emitted in RUN; the top pad row replaces the never-written oldest row.
  always_comb begin
    run_col.r0 = old_px;
    run_col.r1 = mid_px;
    run_col.r2 = in_pixel;
`ifdef DW_PAD_EN
    if (y == YW'(1)) run_col.r0 = '0;
`endif
  end

  // Oldest-row slot is overwritten by the incoming pixel after it has been read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (parity) lb_b[x] <= in_pixel;
      else        lb_a[x] <= in_pixel;
    end
  end

  // Raster counters, FILL/RUN/FLUSH control and registered column outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL;
      x              <= '0;
      y              <= '0;
      parity         <= 1'b0;
      out_valid      <= 1'b0;
      col_q          <= '0;
      out_col        <= '0;
      out_row_first  <= 1'b0;
      out_frame_done <= 1'b0;
`ifdef DW_PAD_EN
      rdy_q          <= 1'b1;
`endif
    end else begin
      out_valid      <= 1'b0;
      out_row_first  <= 1'b0;
      out_frame_done <= 1'b0;
      if (accept) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) begin
          y      <= y_last ? '0 : y + 1'b1;
          parity <= ~parity;
        end
        if (state == RUN) begin
          out_valid     <= 1'b1;
          col_q         <= run_col;
          out_col       <= x;
          out_row_first <= (x == '0);
          if (x_last && y_last) begin
`ifdef DW_PAD_EN
            // Bottom pad pass follows; stall the input until it completes.
            state <= FLUSH;
            rdy_q <= 1'b0;
`else
            state          <= FILL;
            out_frame_done <= 1'b1;
`endif
          end
        end else if (x_last && (y == FILL_ROW)) begin
          state <= RUN;
        end
      end
`ifdef DW_PAD_EN
      else if (state == FLUSH) begin
        // After the frame the parity has toggled, so old/mid are rows H-2/H-1.
        out_valid     <= 1'b1;
        col_q.r0      <= old_px;
        col_q.r1      <= mid_px;
        col_q.r2      <= '0;
        out_col       <= x;
        out_row_first <= (x == '0);
        if (x_last) begin
          x              <= '0;
          state          <= FILL;
          rdy_q          <= 1'b1;
          out_frame_done <= 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
`endif
    end
  end

endmodule
